// File: rtl/sensor_sequencer_pkg.sv
// Shared types and default timing for the lag-measurement sensor sequencer.
package sensor_sequencer_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFlash = 2'd1,
      StDark  = 2'd2
   } seq_state_e;

   localparam int unsigned SensorSyncStages   = 2;
   localparam int unsigned SensorFilterCycles = 27;
   localparam int unsigned FlashFrames        = 30;
   localparam int unsigned DarkFrames         = 30;

endpackage

// File: rtl/sensor_filter.sv
// Photodiode input conditioning: multi-flop synchroniser followed by a run-length debounce.
module sensor_filter
   import sensor_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = SensorSyncStages,
   parameter int unsigned FILTER_CYCLES = SensorFilterCycles
) (
   input  logic clock,
   input  logic reset,
   input  logic sensor_in,
   output logic sensor_level,
   output logic level_rise
);

   localparam int unsigned CntW = $clog2(FILTER_CYCLES + 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CntW-1:0]        run_q, run_d;
   logic                   level_q, level_d;
   logic                   synced;

   assign synced = sync_q[SYNC_STAGES-1];

   // Count consecutive samples disagreeing with the level; any agreeing sample restarts the run.
   always_comb begin
      run_d   = '0;
      level_d = level_q;
      if (synced != level_q) begin
         if (run_q == CntW'(FILTER_CYCLES - 1)) begin
            level_d = ~level_q;
         end else begin
            run_d = run_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q  <= '0;
         run_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], sensor_in};
         run_q   <= run_d;
         level_q <= level_d;
      end
   end

   assign sensor_level = level_q;
   // High in the cycle whose clock edge will raise sensor_level.
   assign level_rise   = level_d & ~level_q;

endmodule

// File: rtl/sensor_sequencer.sv
// Flash/dark test-cycle sequencer: drives the test patch and emits counter start/stop pulses.
module sensor_sequencer
   import sensor_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES   = SensorSyncStages,
   parameter int unsigned FILTER_CYCLES = SensorFilterCycles,
   parameter int unsigned FLASH_FRAMES  = FlashFrames,
   parameter int unsigned DARK_FRAMES   = DarkFrames
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        vsync,
   input  logic        sensor_in,
   output logic        flash_on,
   output logic        reset_counter,
   output logic        sensor_trigger,
   output logic        timeout,
   output logic        sensor_level,
   output logic [15:0] cycle_count
);

   seq_state_e  state_q, state_d;
   logic [7:0]  frame_q, frame_d;
   logic        armed_q, armed_d;
   logic        triggered_q, triggered_d;
   logic        fire_q, fire_d;
   logic        rc_q, rc_d;
   logic        trig_q, trig_d;
   logic        to_q, to_d;
   logic [15:0] count_q, count_d;
   logic        level_rise;
   logic        active;
   logic        fire;

   sensor_filter #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES)
   ) u_filter (
      .clock        (clock),
      .reset        (reset),
      .sensor_in    (sensor_in),
      .sensor_level (sensor_level),
      .level_rise   (level_rise)
   );

   assign active = (state_q != StIdle);
   // Decided on the edge that raises the level, so it still belongs to a cycle ending on that edge.
   assign fire   = enable & active & level_rise & armed_q & ~triggered_q;

   always_comb begin
      state_d     = state_q;
      frame_d     = frame_q;
      armed_d     = armed_q;
      triggered_d = triggered_q;
      fire_d      = 1'b0;
      rc_d        = 1'b0;
      trig_d      = fire_q & enable;
      to_d        = 1'b0;
      count_d     = count_q;
      if (!enable) begin
         state_d = StIdle;
         armed_d = 1'b0;
      end else begin
         if (fire) begin
            fire_d      = 1'b1;
            triggered_d = 1'b1;
         end
         if (active && !sensor_level) begin
            armed_d = 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (vsync) begin
                  state_d     = StFlash;
                  frame_d     = '0;
                  triggered_d = 1'b0;
                  armed_d     = 1'b0;
                  rc_d        = 1'b1;
               end
            end
            StFlash: begin
               if (vsync) begin
                  if (frame_q == 8'(FLASH_FRAMES - 1)) begin
                     state_d = StDark;
                     frame_d = '0;
                  end else begin
                     frame_d = frame_q + 8'd1;
                  end
               end
            end
            StDark: begin
               if (vsync) begin
                  if (frame_q == 8'(DARK_FRAMES - 1)) begin
                     state_d     = StFlash;
                     frame_d     = '0;
                     rc_d        = 1'b1;
                     to_d        = ~triggered_q & ~fire;
                     count_d     = count_q + 16'd1;
                     triggered_d = 1'b0;
                     armed_d     = 1'b0;
                  end else begin
                     frame_d = frame_q + 8'd1;
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         frame_q     <= '0;
         armed_q     <= 1'b0;
         triggered_q <= 1'b0;
         fire_q      <= 1'b0;
         rc_q        <= 1'b0;
         trig_q      <= 1'b0;
         to_q        <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         frame_q     <= frame_d;
         armed_q     <= armed_d;
         triggered_q <= triggered_d;
         fire_q      <= fire_d;
         rc_q        <= rc_d;
         trig_q      <= trig_d;
         to_q        <= to_d;
         count_q     <= count_d;
      end
   end

   assign flash_on       = (state_q == StFlash);
   assign reset_counter  = rc_q;
   assign sensor_trigger = trig_q;
   assign timeout        = to_q;
   assign cycle_count    = count_q;

endmodule

// File: tb/tb_sensor_sequencer.sv
// Scenario bench for sensor_sequencer: expected pulse times queued per scenario, matched by a monitor.
module tb_sensor_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        vsync = 1'b0;
   logic        sensor_in = 1'b0;
   logic        flash_on;
   logic        reset_counter;
   logic        sensor_trigger;
   logic        timeout;
   logic        sensor_level;
   logic [15:0] cycle_count;

   int cyc = 0;
   int base = 0;
   int mt;
   bit vs_on = 1'b0;
   bit mon_on = 1'b0;
   bit lvl_hi = 1'b0;
   int n_tests = 0;
   int n_fail = 0;
   int exp_rc[$];
   int exp_trig[$];
   int exp_to[$];

   sensor_sequencer #(
      .SYNC_STAGES   (2),
      .FILTER_CYCLES (4),
      .FLASH_FRAMES  (2),
      .DARK_FRAMES   (2)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .enable         (enable),
      .vsync          (vsync),
      .sensor_in      (sensor_in),
      .flash_on       (flash_on),
      .reset_counter  (reset_counter),
      .sensor_trigger (sensor_trigger),
      .timeout        (timeout),
      .sensor_level   (sensor_level),
      .cycle_count    (cycle_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, cyc - base);
      end
   endtask

   // Every pulse must match the head of its expectation queue, in time order.
   always @(negedge clock) begin
      if (mon_on) begin
         mt = cyc - base;
         if (sensor_level) lvl_hi = 1'b1;
         if (reset_counter) begin
            if (exp_rc.size() == 0) check("rc_extra", mt, -1);
            else check("rc_time", mt, exp_rc.pop_front());
         end
         if (sensor_trigger) begin
            if (exp_trig.size() == 0) check("trig_extra", mt, -1);
            else check("trig_time", mt, exp_trig.pop_front());
         end
         if (timeout) begin
            if (exp_to.size() == 0) check("timeout_extra", mt, -1);
            else check("timeout_time", mt, exp_to.pop_front());
         end
         if (reset_counter || sensor_trigger)
            check("rc_trig_excl", {31'd0, reset_counter & sensor_trigger}, 0);
      end
   end

   task automatic tick();
      int t;
      @(posedge clock);
      #1;
      t = cyc - base;
      vsync = vs_on && (t > 0) && (t % 100 == 0);
   endtask

   task automatic run_to(input int t);
      while (cyc - base < t) tick();
   endtask

   task automatic peek(input int t);
      run_to(t);
      @(negedge clock);
   endtask

   task automatic start_scenario(input logic en, input logic sens);
      mon_on    = 1'b0;
      vs_on     = 1'b0;
      vsync     = 1'b0;
      reset     = 1'b1;
      enable    = 1'b0;
      sensor_in = sens;
      repeat (3) tick();
      @(negedge clock);
      check("rst_flash_on", flash_on, 0);
      check("rst_reset_counter", reset_counter, 0);
      check("rst_sensor_trigger", sensor_trigger, 0);
      check("rst_timeout", timeout, 0);
      check("rst_sensor_level", sensor_level, 0);
      check("rst_cycle_count", cycle_count, 0);
      reset  = 1'b0;
      enable = en;
      base   = cyc;
      lvl_hi = 1'b0;
      mon_on = 1'b1;
      vs_on  = 1'b1;
   endtask

   task automatic end_scenario();
      check("rc_left", exp_rc.size(), 0);
      check("trig_left", exp_trig.size(), 0);
      check("timeout_left", exp_to.size(), 0);
      exp_rc.delete();
      exp_trig.delete();
      exp_to.delete();
   endtask

   initial begin
      // Flash/dark timing with a dark sensor: timeout on the second reset_counter.
      start_scenario(1'b1, 1'b0);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      exp_to.push_back(501);
      peek(100); check("s1_flash_100", flash_on, 0);
      peek(101); check("s1_flash_101", flash_on, 1);
      peek(300); check("s1_flash_300", flash_on, 1);
      peek(301); check("s1_flash_301", flash_on, 0);
      peek(500); check("s1_flash_500", flash_on, 0);
      check("s1_count_500", cycle_count, 0);
      peek(501); check("s1_flash_501", flash_on, 1);
      check("s1_count_501", cycle_count, 1);
      run_to(520);
      end_scenario();

      // Clean light edge during flash: one trigger, no timeout.
      start_scenario(1'b1, 1'b0);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      run_to(150);
      sensor_in = 1'b1;
      exp_trig.push_back(157);
      peek(155); check("s2_level_155", sensor_level, 0);
      peek(156); check("s2_level_156", sensor_level, 1);
      peek(501); check("s2_count_501", cycle_count, 1);
      run_to(520);
      end_scenario();

      // Sensor lit before flash start and never dark: never armed.
      start_scenario(1'b1, 1'b1);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      exp_to.push_back(501);
      peek(200); check("s4a_level_200", sensor_level, 1);
      run_to(520);
      end_scenario();

      // Lit, then dark long enough to arm, then lit again.
      start_scenario(1'b1, 1'b1);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      run_to(130);
      sensor_in = 1'b0;
      run_to(170);
      sensor_in = 1'b1;
      exp_trig.push_back(177);
      run_to(520);
      end_scenario();

      // Short glitches never qualify.
      start_scenario(1'b1, 1'b0);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      exp_to.push_back(501);
      run_to(150);
      for (int i = 0; i < 10; i++) begin
         sensor_in = 1'b1;
         repeat (3) tick();
         sensor_in = 1'b0;
         tick();
      end
      run_to(520);
      check("s5_glitch_level", lvl_hi, 0);
      end_scenario();

      // Disable mid-flash, re-enable, then reset mid-cycle.
      start_scenario(1'b1, 1'b0);
      exp_rc.push_back(101);
      peek(250); check("s6_flash_250", flash_on, 1);
      enable = 1'b0;
      peek(251); check("s6_flash_251", flash_on, 0);
      run_to(260);
      enable = 1'b1;
      exp_rc.push_back(301);
      peek(300); check("s6_flash_300", flash_on, 0);
      peek(301); check("s6_flash_301", flash_on, 1);
      check("s6_count_301", cycle_count, 0);
      peek(420); check("s6_flash_420", flash_on, 1);
      reset = 1'b1;
      peek(421); check("s6_flash_421", flash_on, 0);
      check("s6_count_421", cycle_count, 0);
      check("s6_level_421", sensor_level, 0);
      run_to(430);
      end_scenario();

      // Level edge on the same clock as the cycle-ending vsync: trigger wins, no timeout.
      start_scenario(1'b1, 1'b0);
      exp_rc.push_back(101);
      exp_rc.push_back(501);
      run_to(495);
      sensor_in = 1'b1;
      exp_trig.push_back(502);
      peek(501); check("s7_level_501", sensor_level, 1);
      check("s7_count_501", cycle_count, 1);
      run_to(520);
      end_scenario();

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
